// File: rtl/intr_ack_control_8259a_pkg.sv
// Shared definitions for the 8259A interrupt acknowledge path.
// Contents: the acknowledge FSM state encoding, the level code reported for a
// spurious acknowledge, the priority rotation helpers, the lowest-bit priority
// resolver and a one-hot to binary encoder.
// Rotation encoding: a rotate value R names the bottom-priority IR, so IR(R+1)
// is the top priority. R=7 gives the fixed order IR0 (highest) .. IR7 (lowest).
package intr_ack_control_8259a_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } ack_state_t;

    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Rotate right by (rotate + 1) so the top-priority IR lands in bit 0.
    function automatic logic [7:0] rotate_right(input logic [7:0] source, input logic [2:0] rotate);
        logic [15:0] doubled;
        logic [3:0]  amount;
        amount  = {1'b0, rotate} + 4'd1;
        doubled = {source, source} >> amount;
        return doubled[7:0];
    endfunction

    // Inverse of rotate_right.
    function automatic logic [7:0] rotate_left(input logic [7:0] source, input logic [2:0] rotate);
        logic [15:0] doubled;
        logic [3:0]  amount;
        amount  = {1'b0, rotate} + 4'd1;
        doubled = {source, source} << amount;
        return doubled[15:8];
    endfunction

    // Keep only the lowest set bit (highest priority in rotated space).
    function automatic logic [7:0] resolv_priority(input logic [7:0] source);
        return source & (~source + 8'd1);
    endfunction

    function automatic logic [2:0] encode_onehot(input logic [7:0] onehot);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                code = 3'(i);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/intr_ack_control_8259a_irr.sv
// irr_8259a: interrupt request register.
// Ports: clock/reset_n (async active-low), interrupt_request_pin (IR0..IR7),
// level_or_edge_triggered (1 = level), clear_request (one-hot acknowledged
// level, valid on the clock latch_in_service is registered),
// interrupt_request_register (IRR).
// A set on the same clock as the acknowledge clear takes precedence.
module irr_8259a (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_pin,
    input  logic       level_or_edge_triggered,
    input  logic [7:0] clear_request,
    output logic [7:0] interrupt_request_register
);

    logic [7:0] pin_prev_r;
    logic [7:0] irr_r;
    logic [7:0] irr_next_s;

    // Next IRR: level mode follows the pins, edge mode latches rising edges.
    always_comb begin
        irr_next_s = irr_r;
        if (level_or_edge_triggered) begin
            irr_next_s = interrupt_request_pin;
        end else begin
            irr_next_s = (irr_r & ~clear_request) | (interrupt_request_pin & ~pin_prev_r);
        end
    end

    // IRR and previous pin sample registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pin_prev_r <= 8'h00;
            irr_r      <= 8'h00;
        end else begin
            pin_prev_r <= interrupt_request_pin;
            irr_r      <= irr_next_s;
        end
    end

    assign interrupt_request_register = irr_r;

endmodule

// File: rtl/intr_ack_control_8259a.sv
// intr_ack_control_8259a: IRR, priority resolver and two-pulse INTA sequence.
// Inputs: IR pins, trigger mode, mask, rotation, in-service one-hot, AEOI
// select, vector base, inta_n. Outputs (all registered): INT, latch_in_service
// strobe with the acknowledged one-hot, AEOI end_of_interrupt, vector byte with
// its enable, and the IRR for status reads.
// Build option: define INTR_ACK_AUTO_EOI_EN to enable automatic EOI; otherwise
// end_of_interrupt is always 0 and auto_eoi_config is ignored.
// ACK_TIMEOUT_CYCLES: WAIT2 clocks before abandoning the sequence (0 = never).
module intr_ack_control_8259a
    import intr_ack_control_8259a_pkg::*;
#(
    parameter int ACK_TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W          = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_pin,
    input  logic       level_or_edge_triggered,
    input  logic [7:0] interrupt_mask,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] highest_level_in_service,
    input  logic       auto_eoi_config,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    output logic       interrupt_to_cpu,
    output logic       latch_in_service,
    output logic [7:0] interrupt,
    output logic [7:0] end_of_interrupt,
    output logic [7:0] out_data,
    output logic       out_data_enable,
    output logic [7:0] interrupt_request_register
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(ACK_TIMEOUT_CYCLES - 1);

    ack_state_t           state_r, state_n;
    logic                 inta_prev_r;
    logic                 int_r, int_n;
    logic                 latch_r, latch_n;
    logic [7:0]           interrupt_r, interrupt_n;
    logic [7:0]           eoi_r, eoi_n;
    logic [7:0]           out_data_r, out_data_n;
    logic                 oe_r, oe_n;
    logic [2:0]           level_r, level_n;
    logic [7:0]           stored_r, stored_n;
    logic                 spurious_r, spurious_n;
    logic [TIMEOUT_W-1:0] count_r, count_n;

    logic [7:0] irr_s;
    logic [7:0] ack_clear_s;
    logic [7:0] winner_rot_s;
    logic [7:0] isr_rot_s;
    logic [7:0] resolved_s;
    logic       valid_s;
    logic       falling_s;

    irr_8259a u_irr (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .interrupt_request_pin      (interrupt_request_pin),
        .level_or_edge_triggered    (level_or_edge_triggered),
        .clear_request              (ack_clear_s),
        .interrupt_request_register (irr_s)
    );

    // Priority resolution: a one-hot lower in rotated space is higher priority,
    // so a plain numeric compare of the rotated one-hots decides "strictly higher".
    always_comb begin
        winner_rot_s = resolv_priority(rotate_right(irr_s & ~interrupt_mask, priority_rotate));
        isr_rot_s    = resolv_priority(rotate_right(highest_level_in_service, priority_rotate));
        resolved_s   = rotate_left(winner_rot_s, priority_rotate);
        valid_s      = (winner_rot_s != 8'h00) && ((isr_rot_s == 8'h00) || (winner_rot_s < isr_rot_s));
        falling_s    = inta_prev_r & ~inta_n;
    end

    // Acknowledge FSM next state and next register values.
    always_comb begin
        state_n     = state_r;
        int_n       = int_r;
        latch_n     = 1'b0;
        interrupt_n = 8'h00;
        eoi_n       = 8'h00;
        out_data_n  = out_data_r;
        oe_n        = oe_r;
        level_n     = level_r;
        stored_n    = stored_r;
        spurious_n  = spurious_r;
        count_n     = {TIMEOUT_W{1'b0}};
        ack_clear_s = 8'h00;
        case (state_r)
            IDLE: begin
                if (falling_s) begin
                    state_n = ACK1;
                    if (valid_s) begin
                        latch_n     = 1'b1;
                        interrupt_n = resolved_s;
                        ack_clear_s = resolved_s;
                        level_n     = encode_onehot(resolved_s);
                        stored_n    = resolved_s;
                        spurious_n  = 1'b0;
                    end else begin
                        level_n    = SPURIOUS_LEVEL;
                        stored_n   = 8'h00;
                        spurious_n = 1'b1;
                    end
                end else begin
                    int_n = valid_s;
                end
            end
            ACK1: begin
                if (inta_n) begin
                    state_n = WAIT2;
                end else begin
                    state_n = ACK1;
                end
            end
            WAIT2: begin
                if (falling_s) begin
                    state_n    = ACK2;
                    int_n      = 1'b0;
                    out_data_n = {vector_base, level_r};
                    oe_n       = 1'b1;
                end else if ((ACK_TIMEOUT_CYCLES != 0) && (count_r == TIMEOUT_LAST)) begin
                    // Abandon: no vector, no EOI; the in-service bit is left set.
                    state_n = IDLE;
                    int_n   = 1'b0;
                end else begin
                    count_n = count_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                end
            end
            ACK2: begin
                int_n = 1'b0;
                if (inta_n) begin
                    state_n    = IDLE;
                    oe_n       = 1'b0;
                    out_data_n = 8'h00;
`ifdef INTR_ACK_AUTO_EOI_EN
                    if (auto_eoi_config && !spurious_r) begin
                        eoi_n = stored_r;
                    end else begin
                        eoi_n = 8'h00;
                    end
`endif
                end else begin
                    state_n = ACK2;
                end
            end
            default: begin
                state_n = IDLE;
                int_n   = 1'b0;
                oe_n    = 1'b0;
            end
        endcase
    end

`ifndef INTR_ACK_AUTO_EOI_EN
    logic unused_aeoi_s;
    assign unused_aeoi_s = auto_eoi_config;
`endif

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            inta_prev_r <= 1'b1;
            int_r       <= 1'b0;
            latch_r     <= 1'b0;
            interrupt_r <= 8'h00;
            eoi_r       <= 8'h00;
            out_data_r  <= 8'h00;
            oe_r        <= 1'b0;
            level_r     <= 3'd0;
            stored_r    <= 8'h00;
            spurious_r  <= 1'b0;
            count_r     <= {TIMEOUT_W{1'b0}};
        end else begin
            state_r     <= state_n;
            inta_prev_r <= inta_n;
            int_r       <= int_n;
            latch_r     <= latch_n;
            interrupt_r <= interrupt_n;
            eoi_r       <= eoi_n;
            out_data_r  <= out_data_n;
            oe_r        <= oe_n;
            level_r     <= level_n;
            stored_r    <= stored_n;
            spurious_r  <= spurious_n;
            count_r     <= count_n;
        end
    end

    assign interrupt_to_cpu           = int_r;
    assign latch_in_service           = latch_r;
    assign interrupt                  = interrupt_r;
    assign end_of_interrupt           = eoi_r;
    assign out_data                   = out_data_r;
    assign out_data_enable            = oe_r;
    assign interrupt_request_register = irr_s;

endmodule
